// File: rtl/rni_link_credit_pkg.sv
// Shared link-state encodings and credit limits for the RN-I link credit engine.
package rni_link_credit_pkg;

  localparam int LL_STATE_WIDTH = 2;

  // Link state encoding is {req, ack}
  typedef enum logic [LL_STATE_WIDTH-1:0] {
    LL_STOP       = 2'b00,
    LL_DEACTIVATE = 2'b01,
    LL_ACTIVATE   = 2'b10,
    LL_RUN        = 2'b11
  } ll_state_e;

  localparam int LL_CRD_MAX = 15;

endpackage

// File: rtl/rni_crd_cnt.sv
// Saturating credit counter: up to two increments and one decrement per cycle.
module rni_crd_cnt #(
  parameter int CNT_W   = 4,
  parameter int MAX_VAL = 15,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             inc2,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_zero,
  output logic             is_max,
  output logic             ovf
);

  localparam logic [CNT_W+1:0] MAX_EXT = (CNT_W+2)'(MAX_VAL);
  localparam logic [CNT_W+1:0] ONE_EXT = (CNT_W+2)'(1);

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W+1:0] v);
    if (v > MAX_EXT) return CNT_W'(MAX_VAL);
    return v[CNT_W-1:0];
  endfunction

  logic [CNT_W+1:0] sum_ext;
  logic [CNT_W+1:0] nxt_ext;

  // Extra headroom bits let the overflow be seen before saturation hides it
  always_comb begin
    sum_ext = {2'b00, cnt} + {{(CNT_W+1){1'b0}}, inc} + {{(CNT_W+1){1'b0}}, inc2};
    nxt_ext = sum_ext;
    if (dec && (sum_ext != '0)) nxt_ext = sum_ext - ONE_EXT;
  end

  assign ovf     = (nxt_ext > MAX_EXT);
  assign is_zero = (cnt == '0);
  assign is_max  = (cnt == CNT_W'(MAX_VAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= CNT_W'(RST_VAL);
    else     cnt <= sat_cnt(nxt_ext);
  end

endmodule

// File: rtl/rni_link_credit.sv
// RN-I link-layer L-credit engine for one CHI channel pair (RX issue/return, TX grant/send/return).
// Optional checker: define RNI_LINK_CRD_CHK_EN to enable the sticky crd_err protocol monitor.
module rni_link_credit
  import rni_link_credit_pkg::*;
#(
  parameter int RX_CRD_NUM    = 15,
  parameter int TX_CRD_MAX    = 15,
  parameter int CRD_CNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LL_STATE_WIDTH-1:0] txlink_state,
  input  logic [LL_STATE_WIDTH-1:0] rxlink_state,
  input  logic                      rxcrd_en,
  input  logic                      lcrd_return_en,
  input  logic                      RXFLITV,
  input  logic                      rx_flit_is_lcrdreturn,
  input  logic                      rx_buf_release,
  output logic                      RXLCRDV,
  output logic                      rxcrd_cnt_full,
  input  logic                      TXLCRDV,
  input  logic                      tx_req_valid,
  output logic                      tx_req_ready,
  output logic                      TXFLITV,
  output logic                      tx_flit_is_lcrdreturn,
  output logic                      txflit_avail,
  output logic                      crd_err
);

  logic [CRD_CNT_WIDTH-1:0] rx_cnt;
  logic [CRD_CNT_WIDTH-1:0] tx_cnt;
  logic rx_zero, rx_max, rx_ovf;
  logic tx_zero, tx_max, tx_ovf;

  logic tx_run, tx_deact;
  logic rx_issue_p0, rx_lcrd_in_p0;
  logic tx_send_p0, tx_ret_p0;
  logic rxlcrdv_p1, txflitv_p1, txlcrd_ret_p1;

  // Stage p0: credit decisions from current counter state
  assign tx_run        = (txlink_state == LL_RUN);
  assign tx_deact      = (txlink_state == LL_DEACTIVATE);
  assign rx_issue_p0   = rxcrd_en & ~rx_zero;
  assign rx_lcrd_in_p0 = RXFLITV & rx_flit_is_lcrdreturn;
  assign tx_send_p0    = tx_req_valid & tx_run & ~tx_zero;
  assign tx_ret_p0     = tx_deact & lcrd_return_en & ~tx_zero;

  // A released buffer entry and a returned credit may land in the same cycle
  rni_crd_cnt #(
    .CNT_W   (CRD_CNT_WIDTH),
    .MAX_VAL (RX_CRD_NUM),
    .RST_VAL (RX_CRD_NUM)
  ) u_rx_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (rx_buf_release),
    .inc2    (rx_lcrd_in_p0),
    .dec     (rx_issue_p0),
    .cnt     (rx_cnt),
    .is_zero (rx_zero),
    .is_max  (rx_max),
    .ovf     (rx_ovf)
  );

  rni_crd_cnt #(
    .CNT_W   (CRD_CNT_WIDTH),
    .MAX_VAL (TX_CRD_MAX),
    .RST_VAL (0)
  ) u_tx_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (TXLCRDV),
    .inc2    (1'b0),
    .dec     (tx_send_p0 | tx_ret_p0),
    .cnt     (tx_cnt),
    .is_zero (tx_zero),
    .is_max  (tx_max),
    .ovf     (tx_ovf)
  );

  // Stage p1: registered link-side strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxlcrdv_p1    <= 1'b0;
      txflitv_p1    <= 1'b0;
      txlcrd_ret_p1 <= 1'b0;
    end else begin
      rxlcrdv_p1    <= rx_issue_p0;
      txflitv_p1    <= tx_send_p0 | tx_ret_p0;
      txlcrd_ret_p1 <= tx_ret_p0;
    end
  end

  assign RXLCRDV               = rxlcrdv_p1;
  assign TXFLITV               = txflitv_p1;
  assign tx_flit_is_lcrdreturn = txlcrd_ret_p1;
  assign tx_req_ready          = tx_send_p0;
  assign txflit_avail          = tx_req_valid;
  assign rxcrd_cnt_full        = rx_max;

`ifdef RNI_LINK_CRD_CHK_EN
  logic [CRD_CNT_WIDTH-1:0] rx_out_cnt;
  logic rx_norm_flit, rx_out_zero, err_set, crd_err_q;
  logic unused_chk;

  assign rx_norm_flit = RXFLITV & ~rx_flit_is_lcrdreturn;
  assign rx_out_zero  = (rx_out_cnt == '0);

  // Credits currently held by the peer: +1 per issue, -1 per flit it spends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_out_cnt <= '0;
    end else if (rx_issue_p0 && !(RXFLITV && !rx_out_zero)) begin
      rx_out_cnt <= rx_out_cnt + CRD_CNT_WIDTH'(1);
    end else if (!rx_issue_p0 && RXFLITV && !rx_out_zero) begin
      rx_out_cnt <= rx_out_cnt - CRD_CNT_WIDTH'(1);
    end
  end

  assign err_set = (TXLCRDV & tx_max)
                 | (TXLCRDV & (txlink_state == LL_STOP))
                 | (rx_norm_flit & rx_out_zero)
                 | rx_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          crd_err_q <= 1'b0;
    else if (err_set) crd_err_q <= 1'b1;
  end

  assign crd_err    = crd_err_q;
  // RX link state is resolved by the handshake block into rxcrd_en
  assign unused_chk = ^{rxlink_state, rx_cnt, tx_cnt, tx_ovf};
`else
  logic unused_nochk;

  assign crd_err      = 1'b0;
  assign unused_nochk = ^{rxlink_state, rx_cnt, tx_cnt, tx_ovf, tx_max, rx_ovf};
`endif

endmodule
